// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and widths for the fetch/EXE SRAM port arbiter.
// Owner encoding and request bus widths used across the memory slice.
package sram_port_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam int SRAM_AW = 32;
    localparam int SRAM_DW = 32;

    // Packed request bus widths: {req, addr} and {req, we, addr, wdata}.
    localparam int INST_REQ_BUS_WIDTH = 1 + SRAM_AW;
    localparam int DATA_REQ_BUS_WIDTH = 1 + 4 + SRAM_AW + SRAM_DW;

    function automatic int streak_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between fetch and EXE requesters.
// Data has priority; a streak counter forces an inst grant when starved.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_req,
    input  logic [SRAM_AW-1:0] inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [SRAM_DW-1:0] inst_rdata,
    input  logic               inst_discard,
    input  logic               data_req,
    input  logic [3:0]         data_we,
    input  logic [SRAM_AW-1:0] data_addr,
    input  logic [SRAM_DW-1:0] data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [SRAM_DW-1:0] data_rdata,
    output logic               sram_en,
    output logic [3:0]         sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata
);

    localparam int SW = streak_width(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak_cnt;
    logic          starved;
    logic          grant_inst;
    logic          grant_data;
    logic          resp_valid;
    owner_e        resp_owner;
    logic          resp_drop;

    assign starved    = (streak_cnt == LIMIT);
    assign grant_inst = !reset && inst_req && (!data_req || starved);
    assign grant_data = !reset && data_req && !grant_inst;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // Steer the granted requester onto the SRAM port.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        unique case (1'b1)
            grant_inst: begin
                sram_en   = 1'b1;
                sram_addr = inst_addr;
            end
            grant_data: begin
                sram_en    = 1'b1;
                sram_we    = data_we;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end
            default: ;
        endcase
    end

    // Count data grants taken while fetch is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_cnt <= '0;
        end else if (grant_inst) begin
            streak_cnt <= '0;
        end else if (grant_data) begin
            if (!inst_req)
                streak_cnt <= '0;
            else if (!starved)
                streak_cnt <= streak_cnt + 1'b1;
        end
    end

    // Remember who owns the SRAM read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_owner <= OWNER_INST;
            resp_drop  <= 1'b0;
        end else begin
            resp_valid <= grant_inst || grant_data;
            resp_owner <= grant_data ? OWNER_DATA : OWNER_INST;
            resp_drop  <= grant_inst && inst_discard;
        end
    end

    assign inst_data_ok = !reset && resp_valid &&
                          (resp_owner == OWNER_INST) &&
                          !resp_drop && !inst_discard;
    assign data_data_ok = !reset && resp_valid &&
                          (resp_owner == OWNER_DATA);

    assign inst_rdata = reset ? '0 : sram_rdata;
    assign data_rdata = reset ? '0 : sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter.
// Grants checked each cycle; responses checked by a separate monitor.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_discard = 1'b0;
    logic        data_req = 1'b0;
    logic [3:0]  data_we = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    sram_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_discard(inst_discard),
        .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          drop;
        bit          is_load;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          waited = 0;
    bit          gi_prev = 0;
    bit          gd_prev = 0;
    bit          last_rd = 0;
    logic [31:0] last_val = '0;
    string       hist = "";

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5a5a_a5a5;
    endfunction

    // One bus cycle: requesters update, then grants are predicted.
    task automatic step(input bit ni, input logic [31:0] ia,
                        input bit nd, input logic [3:0] we,
                        input logic [31:0] da, input logic [31:0] wd,
                        input bit disc, input bit rst);
        bit          gi;
        bit          gd;
        logic [31:0] w;
        resp_t       e;
        @(posedge clk);
        #1;
        cyc++;
        sram_rdata = last_rd ? last_val : $urandom;
        reset = rst;
        if (rst) sb.delete();
        if (gi_prev) inst_req = 1'b0;
        if (gd_prev) data_req = 1'b0;
        if (!inst_req && ni) begin
            inst_req  = 1'b1;
            inst_addr = ia;
        end
        if (!data_req && nd) begin
            data_req   = 1'b1;
            data_we    = we;
            data_addr  = da;
            data_wdata = wd;
        end
        inst_discard = disc;
        @(negedge clk);
        gi = 0;
        gd = 0;
        if (!reset) begin
            if (inst_req && (!data_req || waited >= LIM)) gi = 1;
            else if (data_req) gd = 1;
        end
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(gi));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(gd));
        chk("sram_en", 32'(sram_en), 32'(gi | gd));
        chk("sram_we", 32'(sram_we), gd ? 32'(data_we) : 32'd0);
        chk("sram_addr", sram_addr,
            gi ? inst_addr : (gd ? data_addr : 32'd0));
        chk("sram_wdata", sram_wdata, gd ? data_wdata : 32'd0);
        if (gi) hist = {hist, "I"};
        if (gd) hist = {hist, "D"};
        last_rd = 0;
        if (gi || gd) begin
            e.is_data = gd;
            e.drop    = gi && inst_discard;
            e.is_load = gi || (data_we == 4'h0);
            e.rdata   = rd(gi ? inst_addr : data_addr);
            e.due     = cyc + 1;
            sb.push_back(e);
            last_rd  = e.is_load;
            last_val = e.rdata;
        end
        if (gd && data_we != 4'h0) begin
            w = rd(data_addr);
            for (int b = 0; b < 4; b++)
                if (data_we[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
            mem[data_addr] = w;
        end
        if (reset || gi) waited = 0;
        else if (gd) waited = inst_req ? ((waited < LIM) ? waited + 1 : LIM) : 0;
        gi_prev = gi;
        gd_prev = gd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Response monitor: pops the expected response due this cycle.
    initial begin
        resp_t e;
        bit    have;
        bit    exp_i;
        bit    exp_d;
        forever begin
            @(negedge clk);
            #1;
            have = (sb.size() > 0) && (sb[0].due == cyc);
            exp_i = 0;
            exp_d = 0;
            if (have) begin
                e = sb.pop_front();
                exp_d = e.is_data;
                exp_i = !e.is_data && !e.drop && !inst_discard;
            end
            chk("inst_data_ok", 32'(inst_data_ok), 32'(exp_i));
            chk("data_data_ok", 32'(data_data_ok), 32'(exp_d));
            if (exp_i) chk("inst_rdata", inst_rdata, e.rdata);
            if (exp_d && e.is_load) chk("data_rdata", data_rdata, e.rdata);
        end
    end

    initial begin
        mem[32'h1c00_0000] = 32'h0280_0c0c;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // fetch alone
        step(1, 32'h1c00_0000, 0, 0, 0, 0, 0, 0);
        idle(1);
        // both request: load then store win over fetch
        step(1, 32'h1c00_0004, 1, 4'h0, 32'h0000_1000, 0, 0, 0);
        step(0, 0, 1, 4'hf, 32'h0000_1000, 32'hdead_beef, 0, 0);
        idle(3);
        // both held six cycles: expect DDDDID
        hist = "";
        for (int k = 0; k < 6; k++)
            step(1, 32'h1c00_0008, 1, 4'h0, 32'h0000_1004, 0, 0, 0);
        chk("starve_seq", 32'(hist == "DDDDID"), 32'd1);
        idle(3);
        // fetch discarded in its response cycle, data still completes
        step(1, 32'h1c00_000c, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4'h0, 32'h0000_1000, 0, 1, 0);
        idle(2);
        // alternating fetch/data
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) step(1, 32'h1c00_0010, 0, 0, 0, 0, 0, 0);
            else step(0, 0, 1, 4'h0, 32'h0000_1008, 0, 0, 0);
        end
        idle(1);
        // reset right after a data grant drops its response
        step(0, 0, 1, 4'h0, 32'h0000_1000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h1c00_0000, 0, 0, 0, 0, 0, 0);
        idle(2);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] we;
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            step($urandom_range(0, 99) < 70,
                 32'h1c00_0000 + 32'($urandom_range(0, 15) << 2),
                 $urandom_range(0, 99) < 75, we,
                 32'h0000_1000 + 32'($urandom_range(0, 15) << 2),
                 $urandom,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 1);
        end
        idle(2);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-port synchronous data/instruction SRAM between the fetch stage (instruction requester) and the EXE stage (data requester). Grants at most one access per cycle, drives the SRAM port, and returns a per-requester completion one cycle later. Fixed data priority, with a starvation guard that forces an instruction grant after a configurable run of consecutive data grants.

## Interface
- STARVE_LIMIT, 4 — max consecutive data grants while the instruction request is pending; range 1..15.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- inst_req  in  1  fetch request; held until inst_addr_ok.
- inst_addr  in  32  fetch byte address.
- inst_addr_ok  out  1  fetch request granted this cycle.
- inst_data_ok  out  1  fetch read data valid.
- inst_rdata  out  32  fetch read data.
- inst_discard  in  1  drop the in-flight fetch response (branch flush).
- data_req  in  1  EXE request; held until data_addr_ok.
- data_we  in  4  byte write enables; 0 = load.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request granted this cycle.
- data_data_ok  out  1  load data valid or store complete.
- data_rdata  out  32  load data.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en.

## Operation
- Grant decision (combinational): if only one request, grant it. If both: grant data unless streak_cnt == STARVE_LIMIT, then grant inst.
- streak_cnt: reset 0; on a data grant while inst_req high, increment (saturate at STARVE_LIMIT); on any inst grant, clear to 0; on a data grant with inst_req low, clear to 0.
- Granted requester: addr_ok = 1; sram_en = 1; sram_addr/sram_we/sram_wdata from it (inst: sram_we = 0, sram_wdata = 0). No grant: sram_en = 0, sram_we = 0, addr/wdata = 0.
- Response register: resp_valid, resp_owner (INST/DATA), resp_drop. Loaded every cycle from grant: resp_valid = any grant, resp_owner = granted side, resp_drop = 0.
- inst_discard: if high while resp_valid && resp_owner == INST, or in the same cycle as an inst grant, that response's inst_data_ok is suppressed (set/force resp_drop).
- inst_data_ok = resp_valid && owner INST && !resp_drop && !inst_discard; data_data_ok = resp_valid && owner DATA.
- inst_rdata and data_rdata both drive sram_rdata directly; qualified only by data_ok.
- Stores complete with data_data_ok one cycle after grant, data_rdata don't-care.

## Timing
- Grant latency 0 cycles (addr_ok same cycle as req when selected); response latency exactly 1 cycle after addr_ok.
- Fully pipelined: a new grant every cycle; response of cycle N coexists with grant of cycle N+1.
- No back-pressure on responses: requesters must accept data_ok when it fires.
- Reset: all outputs 0 while reset is high (addr_ok forced 0, sram_en 0); resp_valid 0, streak_cnt 0. Reset mid-transaction: pending response is lost, no data_ok after reset releases.
- Simultaneous requests with streak_cnt < STARVE_LIMIT: data wins, inst holds request.
- Requester dropping req before addr_ok is a protocol violation; behaviour is still one-cycle-accurate (no grant recorded).

## Structure
- Shared package: owner encoding (OWNER_INST = 0, OWNER_DATA = 1), SRAM address/data widths (32), bus-width constants if the request buses are later packed, following the existing *_BUS_WIDTH header defines.
- One module; no sub-module needed. streak counter width $clog2(STARVE_LIMIT+1).

## Test plan
- Inst only, addr 0x1c000000, sram_rdata 0x02800c0c next cycle -> inst_addr_ok same cycle, inst_data_ok + inst_rdata 0x02800c0c one cycle later, data_data_ok 0.
- Both requesting, data load 0x00001000 -> data granted; store data_we 4'hf wdata 0xdeadbeef -> sram_we 4'hf, sram_wdata 0xdeadbeef, data_data_ok next cycle.
- Both held 6 cycles, STARVE_LIMIT 4 -> grants D,D,D,D,I,D; streak_cnt returns to 0 after the I grant.
- Inst granted cycle N, inst_discard in cycle N+1 -> inst_data_ok stays 0; data grant in N+1 still completes in N+2.
- Back-to-back alternating I/D grants for 8 cycles -> one data_ok per cycle, owner matches grant of previous cycle.
- Reset asserted the cycle after a data grant -> data_data_ok 0, all outputs 0, first request after reset granted normally.
